// File: rtl/hydra_config_master_if.sv
// Host-side Hydra link bundle: command, TX UART, RX UART, response and stream signals.
// master modport: the hydra_config_master side.
// slave modport: the host logic and UART side, which drives commands and RX words.
interface hydra_config_master_if #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned TIMEOUT_BITS = 16,
    parameter int unsigned ERRCNT_BITS  = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [7:0]              cmd_chip_id;
    logic [7:0]              cmd_addr;
    logic [7:0]              cmd_wdata;
    logic [TIMEOUT_BITS-1:0] timeout_cycles;
    logic [WIDTH-1:0]        tx_packet;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [WIDTH-1:0]        rx_packet;
    logic                    rx_valid;
    logic                    rsp_valid;
    logic [7:0]              rsp_rdata;
    logic                    rsp_timeout;
    logic [WIDTH-1:0]        stream_packet;
    logic                    stream_valid;
    logic [ERRCNT_BITS-1:0]  parity_err_count;

    modport master (
        input  cmd_valid, cmd_write, cmd_chip_id, cmd_addr, cmd_wdata, timeout_cycles,
        input  tx_ready, rx_packet, rx_valid,
        output cmd_ready, tx_packet, tx_valid, rsp_valid, rsp_rdata, rsp_timeout,
        output stream_packet, stream_valid, parity_err_count
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_chip_id, cmd_addr, cmd_wdata, timeout_cycles,
        output tx_ready, rx_packet, rx_valid,
        input  cmd_ready, tx_packet, tx_valid, rsp_valid, rsp_rdata, rsp_timeout,
        input  stream_packet, stream_valid, parity_err_count
    );
endinterface

// File: rtl/hydra_config_master.sv
// Host-side end of the Hydra chip link.
// Config write and read commands are turned into odd-parity packets for the TX UART.
// Words from the RX UART are checked for parity; a reply that matches the outstanding read
// completes that command, and every other good word is forwarded on the stream port.
// Only one read is outstanding at a time. Its timeout is programmable, and 0 means no timeout.
// Ports:
//   clk          master clock
//   reset_n_clk  asynchronous, active-low reset
//   bus          hydra_config_master_if.master: cmd_*, tx_*, rx_*, rsp_*, stream_*, counters
module hydra_config_master #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned TIMEOUT_BITS = 16,
    parameter int unsigned ERRCNT_BITS  = 16
) (
    input logic                   clk,
    input logic                   reset_n_clk,
    hydra_config_master_if.master bus
);
    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    localparam logic [1:0] TypeWrite = 2'b10;
    localparam logic [1:0] TypeRead  = 2'b11;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    req_write_q, req_write_d;
    logic [7:0]              req_chip_q, req_chip_d;
    logic [7:0]              req_addr_q, req_addr_d;
    logic [TIMEOUT_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [WIDTH-1:0]        tx_packet_q, tx_packet_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [WIDTH-1:0]        stream_packet_q, stream_packet_d;
    logic                    stream_valid_q, stream_valid_d;
    logic [ERRCNT_BITS-1:0]  err_cnt_q, err_cnt_d;

    logic                    rx_parity_ok;
    logic                    rx_match;
    logic                    tmo_expire;
    logic [TIMEOUT_BITS-1:0] tmo_last;

    // Parity bit makes the XOR of the whole word equal to 1.
    function automatic logic [WIDTH-1:0] make_packet(input logic [1:0] pkt_type,
                                                     input logic [7:0] chip,
                                                     input logic [7:0] addr,
                                                     input logic [7:0] data);
        logic [WIDTH-1:0] pkt;
        pkt          = '0;
        pkt[25:0]    = {data, addr, chip, pkt_type};
        pkt[WIDTH-1] = ~^pkt[WIDTH-2:0];
        return pkt;
    endfunction

    assign rx_parity_ok = ^bus.rx_packet;
    assign rx_match     = (state_q == StWait) && bus.rx_valid && rx_parity_ok &&
                          (bus.rx_packet[1:0] == TypeRead) &&
                          (bus.rx_packet[9:2] == req_chip_q) &&
                          (bus.rx_packet[17:10] == req_addr_q);
    assign tmo_last     = bus.timeout_cycles - TIMEOUT_BITS'(1);
    assign tmo_expire   = (bus.timeout_cycles != '0) && (tmo_cnt_q == tmo_last);

    always_comb begin
        state_d         = state_q;
        req_write_d     = req_write_q;
        req_chip_d      = req_chip_q;
        req_addr_d      = req_addr_q;
        tmo_cnt_d       = tmo_cnt_q;
        tx_packet_d     = tx_packet_q;
        tx_valid_d      = tx_valid_q;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = '0;
        rsp_timeout_d   = 1'b0;
        stream_packet_d = stream_packet_q;
        stream_valid_d  = 1'b0;
        err_cnt_d       = err_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    req_write_d = bus.cmd_write;
                    req_chip_d  = bus.cmd_chip_id;
                    req_addr_d  = bus.cmd_addr;
                    tx_packet_d = bus.cmd_write ?
                                  make_packet(TypeWrite, bus.cmd_chip_id, bus.cmd_addr,
                                              bus.cmd_wdata) :
                                  make_packet(TypeRead, bus.cmd_chip_id, bus.cmd_addr, 8'h00);
                    tx_valid_d  = 1'b1;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (req_write_q) begin
                        rsp_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        tmo_cnt_d = '0;
                        state_d   = StWait;
                    end
                end
            end
            StWait: begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_BITS'(1);
                // A reply that arrives in the expiry cycle still counts as a good reply.
                if (rx_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.rx_packet[25:18];
                    state_d     = StDone;
                end else if (tmo_expire) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // RX side runs independently of the command FSM.
        if (bus.rx_valid) begin
            if (!rx_parity_ok) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERRCNT_BITS'(1);
                end
            end else if (!rx_match) begin
                stream_valid_d  = 1'b1;
                stream_packet_d = bus.rx_packet;
            end
        end

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            state_q         <= StIdle;
            cmd_ready_q     <= 1'b0;
            req_write_q     <= 1'b0;
            req_chip_q      <= '0;
            req_addr_q      <= '0;
            tmo_cnt_q       <= '0;
            tx_packet_q     <= '0;
            tx_valid_q      <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_timeout_q   <= 1'b0;
            stream_packet_q <= '0;
            stream_valid_q  <= 1'b0;
            err_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            req_write_q     <= req_write_d;
            req_chip_q      <= req_chip_d;
            req_addr_q      <= req_addr_d;
            tmo_cnt_q       <= tmo_cnt_d;
            tx_packet_q     <= tx_packet_d;
            tx_valid_q      <= tx_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_timeout_q   <= rsp_timeout_d;
            stream_packet_q <= stream_packet_d;
            stream_valid_q  <= stream_valid_d;
            err_cnt_q       <= err_cnt_d;
        end
    end

    assign bus.cmd_ready        = cmd_ready_q;
    assign bus.tx_packet        = tx_packet_q;
    assign bus.tx_valid         = tx_valid_q;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.rsp_timeout      = rsp_timeout_q;
    assign bus.stream_packet    = stream_packet_q;
    assign bus.stream_valid     = stream_valid_q;
    assign bus.parity_err_count = err_cnt_q;
endmodule

// File: tb/tb_hydra_config_master.sv
`timescale 1ns/1ps
module tb_hydra_config_master;
    localparam int unsigned W       = 64;
    localparam int unsigned TB      = 16;
    localparam int unsigned EB      = 4;
    localparam int          ERR_MAX = (1 << EB) - 1;

    logic clk         = 1'b0;
    logic reset_n_clk = 1'b1;
    int   cyc         = 0;
    int   checks      = 0;
    int   errors      = 0;

    hydra_config_master_if #(.WIDTH(W), .TIMEOUT_BITS(TB), .ERRCNT_BITS(EB)) bus ();

    hydra_config_master #(.WIDTH(W), .TIMEOUT_BITS(TB), .ERRCNT_BITS(EB)) dut (
        .clk        (clk),
        .reset_n_clk(reset_n_clk),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        logic       tmo;
        int         due;
    } rsp_t;
    typedef struct {
        logic [W-1:0] pkt;
        int           due;
    } str_t;

    rsp_t         rsp_q[$];
    str_t         str_q[$];
    logic [W-1:0] tx_q[$];
    rsp_t         mon_r;
    str_t         mon_s;

    // Reference model: transaction-level view of the link.
    bit         busy, pending_tx, outstanding, cur_write;
    int         ready_cyc, deadline, exp_err;
    logic [7:0] cur_chip, cur_addr;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] typ, input logic [7:0] chip,
                                        input logic [7:0] addr, input logic [7:0] data,
                                        input bit good);
        logic [W-1:0] p;
        p        = '0;
        p[25:0]  = {data, addr, chip, typ};
        p[W-1]   = ($countones(p[W-2:0]) % 2 == 0);
        if (!good) p[W-1] = ~p[W-1];
        return p;
    endfunction

    function automatic bit model_ready();
        return !busy && (cyc >= ready_cyc);
    endfunction

    task automatic finish_cmd(input int e);
        busy      = 0;
        ready_cyc = e + 1;
    endtask

    task automatic model_rx(input logic [W-1:0] pkt, input int e);
        rsp_t r;
        str_t s;
        if ($countones(pkt) % 2 == 0) begin
            if (exp_err < ERR_MAX) exp_err++;
        end else if (outstanding && pkt[1:0] == 2'b11 && pkt[9:2] == cur_chip &&
                     pkt[17:10] == cur_addr) begin
            r.rdata = pkt[25:18];
            r.tmo   = 1'b0;
            r.due   = e;
            rsp_q.push_back(r);
            outstanding = 0;
            finish_cmd(e);
        end else begin
            s.pkt = pkt;
            s.due = e;
            str_q.push_back(s);
        end
    endtask

    // Compares registered status, then models the coming clock edge and advances to it.
    task automatic tick();
        int   e;
        rsp_t r;
        check("cmd_ready", bus.cmd_ready, model_ready());
        check("tx_valid", bus.tx_valid, pending_tx);
        check("parity_err_count", bus.parity_err_count, exp_err);
        e = cyc + 1;
        if (bus.rx_valid) model_rx(bus.rx_packet, e);
        if (outstanding && deadline != 0 && e == deadline) begin
            r.rdata = 8'h00;
            r.tmo   = 1'b1;
            r.due   = e;
            rsp_q.push_back(r);
            outstanding = 0;
            finish_cmd(e);
        end
        if (pending_tx && bus.tx_ready) begin
            pending_tx = 0;
            if (cur_write) begin
                r.rdata = 8'h00;
                r.tmo   = 1'b0;
                r.due   = e;
                rsp_q.push_back(r);
                finish_cmd(e);
            end else begin
                outstanding = 1;
                deadline    = (bus.timeout_cycles == 0) ? 0 : e + int'(bus.timeout_cycles);
            end
        end else if (model_ready() && bus.cmd_valid) begin
            busy       = 1;
            pending_tx = 1;
            cur_write  = bus.cmd_write;
            cur_chip   = bus.cmd_chip_id;
            cur_addr   = bus.cmd_addr;
            tx_q.push_back(mk(cur_write ? 2'b10 : 2'b11, cur_chip, cur_addr,
                              cur_write ? bus.cmd_wdata : 8'h00, 1'b1));
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input bit wr, input logic [7:0] chip, input logic [7:0] addr,
                         input logic [7:0] data);
        int n;
        n = 0;
        while (!model_ready() && n < 300) begin
            tick();
            n++;
        end
        if (!model_ready()) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: got busy after 300 cycles, required idle (cycle %0d)", cyc);
            return;
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = wr;
        bus.cmd_chip_id = chip;
        bus.cmd_addr    = addr;
        bus.cmd_wdata   = data;
        tick();
        // Scramble the command fields; they must not leak into the sent packet.
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'($urandom);
        bus.cmd_chip_id = 8'($urandom);
        bus.cmd_addr    = 8'($urandom);
        bus.cmd_wdata   = 8'($urandom);
    endtask

    task automatic send_tx(input int stall);
        bus.tx_ready = 1'b0;
        idle(stall);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic inject(input logic [W-1:0] pkt);
        bus.rx_valid  = 1'b1;
        bus.rx_packet = pkt;
        tick();
    endtask

    task automatic reset_pulse();
        reset_n_clk   = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.rx_valid  = 1'b0;
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_packet", bus.tx_packet, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_stream_valid", bus.stream_valid, 0);
        check("rst_stream_packet", bus.stream_packet, 0);
        check("rst_parity_err_count", bus.parity_err_count, 0);
        busy        = 0;
        pending_tx  = 0;
        outstanding = 0;
        exp_err     = 0;
        tx_q.delete();
        rsp_q.delete();
        str_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n_clk = 1'b1;
        ready_cyc   = cyc + 1;
    endtask

    task automatic rand_op();
        bit         wr;
        logic [7:0] chip, addr, data;
        int         tmo, rdly;
        wr   = 1'($urandom_range(0, 1));
        chip = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'($urandom);
        addr = 8'($urandom);
        data = 8'($urandom);
        tmo  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(3, 30));
        rdly = int'($urandom_range(1, (tmo == 0) ? 20 : tmo + 8));
        bus.timeout_cycles = TB'(tmo);
        issue(wr, chip, addr, data);
        send_tx(int'($urandom_range(0, 3)));
        if (!wr) begin
            for (int k = 0; k < 80 && (busy || k <= rdly); k++) begin
                if (k == rdly) inject(mk(2'b11, chip, addr, 8'($urandom), 1'b1));
                else if ($urandom_range(0, 3) == 0) inject({$urandom, $urandom});
                else tick();
            end
        end
    endtask

    // Output monitor: pops the scoreboard whenever the DUT presents something.
    always @(negedge clk) begin
        if (bus.tx_valid) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got tx_valid=1 packet 0x%0h, required none", bus.tx_packet);
            end else begin
                check("tx_packet", bus.tx_packet, tx_q[0]);
                if (bus.tx_ready) void'(tx_q.pop_front());
            end
        end
        if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 rdata 0x%0h timeout %0d, required none (cycle %0d)",
                         bus.rsp_rdata, bus.rsp_timeout, cyc);
            end else begin
                mon_r = rsp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, mon_r.rdata);
                check("rsp_timeout", bus.rsp_timeout, mon_r.tmo);
                check("rsp_cycle", cyc, mon_r.due);
            end
        end
        if (bus.stream_valid) begin
            if (str_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_unexpected: got stream_valid=1 packet 0x%0h, required none (cycle %0d)",
                         bus.stream_packet, cyc);
            end else begin
                mon_s = str_q.pop_front();
                check("stream_packet", bus.stream_packet, mon_s.pkt);
                check("stream_cycle", cyc, mon_s.due);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test, required finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid      = 1'b0;
        bus.cmd_write      = 1'b0;
        bus.cmd_chip_id    = '0;
        bus.cmd_addr       = '0;
        bus.cmd_wdata      = '0;
        bus.timeout_cycles = '0;
        bus.tx_ready       = 1'b0;
        bus.rx_packet      = '0;
        bus.rx_valid       = 1'b0;
        busy = 0; pending_tx = 0; outstanding = 0; cur_write = 0;
        ready_cyc = 0; deadline = 0; exp_err = 0; cur_chip = '0; cur_addr = '0;
        #2;
        reset_pulse();

        // Write with a stalled UART.
        issue(1'b1, 8'h12, 8'h05, 8'hA5);
        send_tx(5);
        idle(3);

        // Read answered by a matching reply.
        bus.timeout_cycles = TB'(200);
        issue(1'b0, 8'h12, 8'h40, 8'h00);
        send_tx(1);
        idle(4);
        inject(mk(2'b11, 8'h12, 8'h40, 8'h3C, 1'b1));
        idle(3);

        // Timeout of 100 cycles, then no timeout at all for 10000 cycles.
        bus.timeout_cycles = TB'(100);
        issue(1'b0, 8'h12, 8'h41, 8'h00);
        send_tx(0);
        idle(110);
        bus.timeout_cycles = TB'(0);
        issue(1'b0, 8'h12, 8'h42, 8'h00);
        send_tx(2);
        idle(10000);
        inject(mk(2'b11, 8'h12, 8'h42, 8'h77, 1'b1));
        idle(3);

        // Traffic that must not complete the read, then the real reply.
        issue(1'b0, 8'h12, 8'h40, 8'h00);
        send_tx(0);
        idle(2);
        inject(mk(2'b00, 8'h12, 8'h40, 8'h55, 1'b1));
        inject(mk(2'b11, 8'h13, 8'h40, 8'h66, 1'b1));
        inject(mk(2'b11, 8'h12, 8'h40, 8'h3C, 1'b0));
        inject(mk(2'b11, 8'h12, 8'h40, 8'h99, 1'b1));
        idle(3);

        // Reply lands on the expiry cycle.
        bus.timeout_cycles = TB'(20);
        issue(1'b0, 8'h21, 8'h22, 8'h00);
        send_tx(0);
        for (int i = 0; i < 40 && cyc < deadline - 1; i++) tick();
        inject(mk(2'b11, 8'h21, 8'h22, 8'hC3, 1'b1));
        idle(3);

        // Parity error counter saturation.
        for (int i = 0; i < ERR_MAX + 5; i++) inject(mk(2'b11, 8'h12, 8'h40, 8'(i), 1'b0));
        idle(2);

        // Reset during SEND.
        issue(1'b1, 8'h30, 8'h31, 8'h32);
        idle(2);
        reset_pulse();
        issue(1'b1, 8'h33, 8'h34, 8'h35);
        send_tx(1);
        idle(3);

        // Reset during WAIT; the late reply is plain stream traffic afterwards.
        bus.timeout_cycles = TB'(0);
        issue(1'b0, 8'h12, 8'h50, 8'h00);
        send_tx(0);
        idle(5);
        reset_pulse();
        idle(2);
        inject(mk(2'b11, 8'h12, 8'h50, 8'h11, 1'b1));
        issue(1'b0, 8'h12, 8'h51, 8'h00);
        send_tx(0);
        idle(3);
        inject(mk(2'b11, 8'h12, 8'h51, 8'h22, 1'b1));
        idle(3);

        // Randomised mix.
        repeat (40) rand_op();
        idle(20);

        check("tx_scoreboard_empty", tx_q.size(), 0);
        check("rsp_scoreboard_empty", rsp_q.size(), 0);
        check("stream_scoreboard_empty", str_q.size(), 0);
        check("model_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
